// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// A result is computed at Start, held pending for a fixed latency, then committed.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMadd  = 3'd5;
  localparam logic [2:0] OpMthi  = 3'd6;
  localparam logic [2:0] OpMtlo  = 3'd7;

  typedef enum logic {StIdle, StRun} state_e;

  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [31:0]     r_hi, w_hi_d;
  logic [31:0]     r_lo, w_lo_d;
  logic [31:0]     r_phi, w_phi_d;
  logic [31:0]     r_plo, w_plo_d;
  state_e          w_state;

  logic [63:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u, w_madd;
  logic        w_a_neg, w_b_neg, w_signed_div;
  logic [31:0] w_a_mag, w_b_mag, w_dvd, w_dvs, w_q_mag, w_r_mag, w_q, w_r;

  // Multiplies are done at 64 bits; only the low 64 bits of the product are kept.
  assign w_a_sx   = {{32{i_a[31]}}, i_a};
  assign w_b_sx   = {{32{i_b[31]}}, i_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
  assign w_madd   = {r_hi, r_lo} + w_prod_s;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_signed_div = (i_md_op == OpDiv);
  assign w_a_neg      = w_signed_div & i_a[31];
  assign w_b_neg      = w_signed_div & i_b[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag      = w_b_neg ? (32'd0 - i_b) : i_b;
  assign w_dvd        = w_a_mag;
  assign w_dvs        = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_dvd / w_dvs;
  assign w_r_mag      = w_dvd % w_dvs;
  assign w_q          = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r          = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  assign w_state = (r_cnt == '0) ? StIdle : StRun;

  always_comb begin
    w_cnt_d = r_cnt;
    w_hi_d  = r_hi;
    w_lo_d  = r_lo;
    w_phi_d = r_phi;
    w_plo_d = r_plo;
    unique case (w_state)
      StIdle: begin
        if (i_start && (i_md_op >= OpMult) && (i_md_op <= OpMadd)) begin
          case (i_md_op)
            OpMult:  {w_phi_d, w_plo_d} = w_prod_s;
            OpMultu: {w_phi_d, w_plo_d} = w_prod_u;
            OpMadd:  {w_phi_d, w_plo_d} = w_madd;
            default: begin
              if (i_b == 32'd0) begin
                w_phi_d = r_hi;
                w_plo_d = r_lo;
              end else begin
                w_phi_d = w_r;
                w_plo_d = w_q;
              end
            end
          endcase
          w_cnt_d = ((i_md_op == OpDiv) || (i_md_op == OpDivu)) ? DivLoad : MultLoad;
        end else if (i_md_op == OpMthi) begin
          w_hi_d = i_a;
        end else if (i_md_op == OpMtlo) begin
          w_lo_d = i_a;
        end
      end
      StRun: begin
        if (r_cnt == CntW'(1)) begin
          w_hi_d  = r_phi;
          w_lo_d  = r_plo;
          w_cnt_d = '0;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: w_cnt_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_phi <= '0;
      r_plo <= '0;
    end else begin
      r_cnt <= w_cnt_d;
      r_hi  <= w_hi_d;
      r_lo  <= w_lo_d;
      r_phi <= w_phi_d;
      r_plo <= w_plo_d;
    end
  end

  assign o_busy = (w_state == StRun);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle multiply/divide unit (MDU) in the EX stage; owns the HI/LO architectural registers.
- Responds to the instruction decoder's `Start` pulse and MD op code: latches operands, holds `Busy` for a fixed latency, then commits the result to HI/LO.
- Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.
- The decoder/hazard unit stalls any MD-class instruction in ID while `Start` or `Busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU/MADD.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `Start` in 1: one-cycle request for a MULT/MULTU/DIV/DIVU/MADD in EX.
- `MDOp` in 3: op code.
  - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MTHI, 7 MTLO.
- `A` in 32: rs operand, already forwarded.
- `B` in 32: rt operand, already forwarded.
- `Busy` out 1: operation in flight.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- State: `cnt` (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)), pending-result registers `pHI`/`pLO`, plus `HI`/`LO`.
- Two states, derived from `cnt`:
  - IDLE: `cnt == 0`.
  - RUN: `cnt != 0`.
- `Busy = (cnt != 0)`, registered-state derived.
- Start is accepted only in IDLE with `MDOp` in 1..5. On acceptance, at the same edge:
  - `pHI`/`pLO` are loaded with the full result computed from `A`, `B` and the current `HI`/`LO`.
  - `cnt` is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN: `cnt` decrements each edge. At the edge where `cnt == 1`, `HI <= pHI`, `LO <= pLO`, and `cnt <= 0`.
- Arithmetic (64-bit products, wrap modulo 2^64):
  - MULT: `{HI,LO} = signed(A) * signed(B)`.
  - MULTU: `{HI,LO} = unsigned(A) * unsigned(B)`.
  - MADD: `{HI,LO} = {HI,LO} + signed(A) * signed(B)`, using `HI`/`LO` at the Start edge.
  - DIV: `LO = A / B` and `HI = A % B`, signed, truncated toward zero; the remainder takes the sign of the dividend.
  - DIVU: same as DIV, unsigned.
  - DIV with `A = 0x80000000` and `B = 0xFFFFFFFF`: `LO = 0x80000000`, `HI = 0`.
  - DIV/DIVU with `B == 0`: `pHI`/`pLO` are loaded with the current `HI`/`LO`. `Busy` still runs the full DIV_CYCLES, and HI/LO are unchanged at the end.
- MTHI/MTLO (`MDOp` 6/7, `Start` ignored):
  - Act only in IDLE.
  - At the edge: `HI <= A` (MTHI) or `LO <= A` (MTLO).
  - No `Busy`.
- Illegal or ignored cases:
  - `Start` or MTHI/MTLO while `Busy`: ignored, no state change. The hazard unit guarantees this does not occur; the bench checks that it is harmless.
  - `Start` with `MDOp` of 0, 6 or 7: no multi-cycle operation.
- HI/LO reads are combinational from the `HI`/`LO` registers. MFHI/MFLO are stalled while `Busy`, so they never see pending data.

## Timing
- Reset (`reset == 0` at a rising edge): `cnt = 0`, `Busy = 0`, `HI = 0`, `LO = 0`, `pHI = 0`, `pLO = 0`.
- Reset has priority over everything, including mid-operation: an in-flight op is abandoned and HI/LO are zeroed.
- `Start` is sampled high at edge E0:
  - `Busy` is 1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - `Busy` falls at edge E0+N.
  - `HI`/`LO` take the new value at edge E0+N, the same edge at which `Busy` falls.
- Back-to-back: a new `Start` at edge E0+N (`Busy` was still 1 in the preceding cycle) is ignored. The earliest accepted restart is edge E0+N+1.
- MTHI/MTLO latency is 1 edge. A write in the same cycle as an accepted `Start` cannot occur, because `MDOp` is a single code.
- No combinational path from `Start` to `Busy`; the decoder ORs `Start` externally for its stall.

## Test plan
- Reset, then MULT with A=0xFFFFFFFE (-2), B=3:
  - `Busy` high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO unchanged before the final edge.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV with A=0xFFFFFFF9 (-7), B=2:
  - `Busy` for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with A=7, B=0 afterwards -> HI/LO unchanged after 10 busy cycles.
- MTHI 0x12345678, then MTLO 0x1, then MADD with A=2, B=3 -> after 5 cycles HI=0x12345678, LO=0x7.
- `Start` (MULT) pulsed at cycles 2 and 4 of an in-flight DIV, plus MTLO while busy:
  - All ignored.
  - DIV completes at cycle 10 with the correct result.
- `reset` asserted at busy cycle 3 of a MULT -> next cycle `Busy=0`, HI=LO=0, and no late commit afterwards.
